// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative RV32M mul/div unit.
// The unit is the slave; the pipeline (or a testbench) drives the master side.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] op_a_i;
  logic [DATA_WIDTH-1:0] op_b_i;
  logic [ADDR_WIDTH-1:0] rd_i;
  logic                  flush_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic [ADDR_WIDTH-1:0] rd_o;

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
    output ready_o, valid_o, result_o, rd_o
  );

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
    input  ready_o, valid_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring divider
// sharing one W-iteration datapath; divide-by-zero and signed overflow resolve at accept.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);
  localparam logic [W-1:0]  S_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_ready;
  logic            r_valid;
  logic [2:0]      r_func;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_rd_out;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_result;
  logic [CW-1:0]   r_count;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [W-1:0]    w_fast_val;
  logic            w_accept;
  logic            w_last;
  logic            w_step_en;

  logic [W:0]      w_sum;
  logic [W:0]      w_rs;
  logic [W-1:0]    w_step_hi;
  logic [W-1:0]    w_step_lo;
  logic [2*W-1:0]  w_prod_mag;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_res;

  // Accept-time operand decode: signedness, magnitudes and the fast-path cases
  always_comb begin
    w_is_div   = bus.funct3_i[2];
    w_a_signed = w_is_div ? ~bus.funct3_i[0]
                          : (bus.funct3_i[1:0] == 2'b01) || (bus.funct3_i[1:0] == 2'b10);
    w_b_signed = w_is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] == 2'b01);
    w_a_neg    = w_a_signed & bus.op_a_i[W-1];
    w_b_neg    = w_b_signed & bus.op_b_i[W-1];
    w_mag_a    = w_a_neg ? W'(~bus.op_a_i + 1'b1) : bus.op_a_i;
    w_mag_b    = w_b_neg ? W'(~bus.op_b_i + 1'b1) : bus.op_b_i;
    w_div_zero = w_is_div & (bus.op_b_i == '0);
    w_div_ovf  = w_is_div & ~bus.funct3_i[0] & (bus.op_a_i == S_MIN) & (bus.op_b_i == '1);
    w_fast     = w_div_zero | w_div_ovf;
    w_fast_val = '0;
    if (w_div_zero) begin
      w_fast_val = bus.funct3_i[1] ? bus.op_a_i : '1;
    end else if (w_div_ovf) begin
      w_fast_val = bus.funct3_i[1] ? '0 : bus.op_a_i;
    end
  end

  // One iteration of the shared datapath plus sign fix-up of the finished result
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_rs      = {r_hi, r_lo[W-1]};
    w_step_hi = w_sum[W:1];
    w_step_lo = {w_sum[0], r_lo[W-1:1]};
    if (r_func[2]) begin
      if (w_rs >= {1'b0, r_opb}) begin
        w_step_hi = W'(w_rs - {1'b0, r_opb});
        w_step_lo = {r_lo[W-2:0], 1'b1};
      end else begin
        w_step_hi = w_rs[W-1:0];
        w_step_lo = {r_lo[W-2:0], 1'b0};
      end
    end
    w_prod_mag = {w_step_hi, w_step_lo};
    w_prod     = r_neg_q ? (2*W)'(~w_prod_mag + 1'b1) : w_prod_mag;
    if (!r_func[2]) begin
      w_res = (r_func[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    end else if (!r_func[1]) begin
      w_res = r_neg_q ? W'(~w_step_lo + 1'b1) : w_step_lo;
    end else begin
      w_res = r_neg_r ? W'(~w_step_hi + 1'b1) : w_step_hi;
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_step_en = 1'b0;
    w_last    = (r_count == LAST);
    case (r_state)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          w_accept = 1'b1;
          w_next   = w_fast ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          w_next = S_IDLE;
        end else begin
          w_step_en = 1'b1;
          if (w_last) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; ready/valid are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_DONE);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func   <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_func  <= bus.funct3_i;
      r_rd    <= bus.rd_i;
      r_hi    <= '0;
      r_lo    <= w_mag_a;
      r_opb   <= w_mag_b;
      r_count <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_fast) begin
        r_result <= w_fast_val;
        r_rd_out <= bus.rd_i;
      end
    end else if (w_step_en) begin
      r_hi    <= w_step_hi;
      r_lo    <= w_step_lo;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_result <= w_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
  assign bus.rd_o     = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and golden-model checks of muldiv_unit at DATA_WIDTH 32 and 16.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  muldiv_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  muldiv_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus16 ();

  muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  muldiv_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gold(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b};               r = p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};         r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};               r = p[63:32]; end
      3'd4: r = (b == 0) ? '1 : (a == MIN32 && b == '1) ? a : 32'(sa / sb);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a : (a == MIN32 && b == '1) ? '0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Presents one request for one cycle; returns at the negedge of cycle 1 after accept
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = f; bus.op_a_i = a; bus.op_b_i = b; bus.rd_i = rd;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.valid_o && n <= int'(W) + 4) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int lat);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(bus.ready_o), 32'd1);
    issue(f, a, b, rd);
    wait_valid(n);
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, bus.result_o, exp);
    chk({tag, ".rd"}, 32'(bus.rd_o), 32'(rd));
  endtask

  task automatic run_flush(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input int k);
    int seen;
    seen = 0;
    issue(f, a, b, rd);
    repeat (k - 1) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk({tag, ".rdy"}, 32'(bus.ready_o), 32'd1);
    for (int i = 0; i < int'(W) + 2; i++) begin
      if (bus.valid_o) seen++;
      @(negedge clk);
    end
    chk({tag, ".novalid"}, 32'(seen), 32'd0);
  endtask

  task automatic run16(input string tag, input logic [2:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp, input int lat);
    int n;
    @(negedge clk);
    bus16.start_i = 1'b1; bus16.funct3_i = f; bus16.op_a_i = a; bus16.op_b_i = b;
    bus16.rd_i = 5'd21;
    @(negedge clk);
    bus16.start_i = 1'b0;
    n = 1;
    while (!bus16.valid_o && n <= 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, 32'(bus16.result_o), 32'(exp));
  endtask

  initial begin
    int n;
    int seen;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    bit          fast;

    rst_n = 1'b0;
    bus.start_i = 0; bus.funct3_i = 0; bus.op_a_i = 0; bus.op_b_i = 0; bus.rd_i = 0;
    bus.flush_i = 0;
    bus16.start_i = 0; bus16.funct3_i = 0; bus16.op_a_i = 0; bus16.op_b_i = 0;
    bus16.rd_i = 0; bus16.flush_i = 0;
    repeat (2) @(negedge clk);
    chk("reset.ready", 32'(bus.ready_o), 32'd1);
    chk("reset.valid", 32'(bus.valid_o), 32'd0);
    chk("reset.result", bus.result_o, 32'd0);
    chk("reset.rd", 32'(bus.rd_o), 32'd0);
    rst_n = 1'b1;

    run("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
    run("mulh",   3'd1, MIN32, MIN32, 5'd2, 32'h4000_0000, 33);
    run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 33);
    run("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run("divu",   3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run("remu",   3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run("div0",   3'd4, 32'd1234, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run("rem0",   3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run("divu0",  3'd5, 32'd77, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    run("divovf", 3'd4, MIN32, 32'hFFFF_FFFF, 5'd12, MIN32, 1);
    run("removf", 3'd6, MIN32, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

    // Flush at BUSY cycle 10, then the unit must still work
    run_flush("flush10", 3'd5, 32'd100, 32'd7, 5'd14, 10);
    chk("flush10.rd_hold", 32'(bus.rd_o), 32'd13);
    run("after_flush", 3'd0, 32'd6, 32'd7, 5'd15, 32'd42, 33);

    // Same-cycle start and flush in IDLE: request dropped
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'd0;
    bus.op_a_i = 32'd3; bus.op_b_i = 32'd3; bus.rd_i = 5'd16;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    chk("startflush.rdy", 32'(bus.ready_o), 32'd1);
    seen = 0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      if (bus.valid_o) seen++;
      @(negedge clk);
    end
    chk("startflush.novalid", 32'(seen), 32'd0);
    chk("startflush.rd_hold", 32'(bus.rd_o), 32'd15);

    // Start held through BUSY: second request only taken after DONE
    bus.start_i = 1'b1; bus.funct3_i = 3'd0; bus.op_a_i = 32'd6; bus.op_b_i = 32'd7;
    bus.rd_i = 5'd3;
    @(negedge clk);
    bus.funct3_i = 3'd5; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7; bus.rd_i = 5'd4;
    wait_valid(n);
    chk("hold1.lat", 32'(n), 32'd33);
    chk("hold1.res", bus.result_o, 32'd42);
    chk("hold1.rd", 32'(bus.rd_o), 32'd3);
    @(negedge clk);
    chk("hold.rdy", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_valid(n);
    chk("hold2.lat", 32'(n), 32'd33);
    chk("hold2.res", bus.result_o, 32'd14);
    chk("hold2.rd", 32'(bus.rd_o), 32'd4);

    // Reset asserted mid-BUSY
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.ready", 32'(bus.ready_o), 32'd1);
    chk("rstmid.valid", 32'(bus.valid_o), 32'd0);
    chk("rstmid.result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      if (bus.valid_o) seen++;
      @(negedge clk);
    end
    chk("rstmid.nostale", 32'(seen), 32'd0);

    // Random ops against the golden model, with occasional flushes
    for (int i = 0; i < 300; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN32; b = '1; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      fast = f[2] && ((b == 0) || (!f[0] && a == MIN32 && b == '1));
      if (!fast && $urandom_range(0, 5) == 0) begin
        run_flush($sformatf("rndflush%0d", i), f, a, b, rd, $urandom_range(1, W));
      end else begin
        run($sformatf("rnd%0d", i), f, a, b, rd, gold(f, a, b), fast ? 1 : 33);
      end
    end

    // Narrow instance
    run16("w16.mul",    3'd0, 16'd7, 16'hFFFD, 16'hFFEB, 17);
    run16("w16.mulh",   3'd1, 16'h8000, 16'h8000, 16'h4000, 17);
    run16("w16.mulhu",  3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("w16.mulhsu", 3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 17);
    run16("w16.div",    3'd4, 16'hFFF9, 16'd2, 16'hFFFD, 17);
    run16("w16.rem",    3'd6, 16'hFFF9, 16'd2, 16'hFFFF, 17);
    run16("w16.divu",   3'd5, 16'd100, 16'd7, 16'd14, 17);
    run16("w16.remu",   3'd7, 16'd100, 16'd7, 16'd2, 17);
    run16("w16.div0",   3'd4, 16'd9, 16'd0, 16'hFFFF, 1);
    run16("w16.rem0",   3'd6, 16'd5, 16'd0, 16'd5, 1);
    run16("w16.divovf", 3'd4, 16'h8000, 16'hFFFF, 16'h8000, 1);
    run16("w16.removf", 3'd6, 16'h8000, 16'hFFFF, 16'd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
